// File: rtl/spi_transmitter.sv
// SPI master transmitter: 16-bit words MSB first, mode 0 (serial_clk idles low, data valid on rising edge).
// Define SPI_TX_PAD_EN to stretch each frame to 32 serial_clk cycles, the last 16 carrying zeros.
module spi_transmitter #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        serial_clk,
    output logic        chip_select,
    output logic        mosi,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT_HI,
        SHIFT_LO,
        GAP
    } state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

`ifdef SPI_TX_PAD_EN
    localparam logic [4:0] LAST_BIT = 5'd31;
`else
    localparam logic [4:0] LAST_BIT = 5'd15;
`endif

    state_t      state_reg, state_next;
    logic [7:0]  div_cnt_reg, div_cnt_next;
    logic [4:0]  bit_cnt_reg, bit_cnt_next;
    logic [15:0] shift_reg, shift_next;
    logic        phase_end;
    logic        in_frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
        end
    end

    assign phase_end = (div_cnt_reg == 8'd0);

    // bit_cnt_reg holds (rising edges so far - 1) so that 32 edges still fit in 5 bits.
    always_comb begin
        state_next   = state_reg;
        div_cnt_next = phase_end ? div_cnt_reg : div_cnt_reg - 8'd1;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        case (state_reg)
            IDLE: begin
                if (tx_valid) begin
                    state_next   = LEAD;
                    div_cnt_next = DIV_LOAD;
                    bit_cnt_next = '0;
                    shift_next   = tx_data;
                end
            end
            LEAD: begin
                if (phase_end) begin
                    state_next   = SHIFT_HI;
                    div_cnt_next = DIV_LOAD;
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    state_next   = SHIFT_LO;
                    div_cnt_next = DIV_LOAD;
                    // Hold the final bit through the last low phase instead of shifting in a zero.
                    if (bit_cnt_reg != LAST_BIT) begin
                        shift_next = {shift_reg[14:0], 1'b0};
                    end
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_next   = GAP;
                        div_cnt_next = GAP_LOAD;
                    end else begin
                        state_next   = SHIFT_HI;
                        div_cnt_next = DIV_LOAD;
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                    end
                end
            end
            GAP: begin
                if (phase_end) begin
                    state_next   = IDLE;
                    div_cnt_next = '0;
                end
            end
            default: begin
                state_next   = IDLE;
                div_cnt_next = '0;
            end
        endcase
    end

    assign in_frame    = (state_reg == LEAD) || (state_reg == SHIFT_HI) || (state_reg == SHIFT_LO);
    assign tx_ready    = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign serial_clk  = (state_reg == SHIFT_HI);
    assign chip_select = ~in_frame;
    assign mosi        = in_frame & shift_reg[15];
    assign frame_done  = (state_reg == GAP) && phase_end;

endmodule

// File: tb/tb_spi_transmitter.sv
// Directed bench for spi_transmitter: instance u_a (CLK_DIV=2) and u_b (CLK_DIV=1), both GAP_CYCLES=4,
// with a mode-0 receiver model that samples mosi on serial_clk rising edges.
module tb_spi_transmitter;

`ifdef SPI_TX_PAD_EN
    localparam int          NB         = 32;
    localparam logic [15:0] BASIC_WORD = 16'h5A5A;
    localparam int          ONES_FFFF  = 32;
`else
    localparam int          NB         = 16;
    localparam logic [15:0] BASIC_WORD = 16'hA5C3;
    localparam int          ONES_FFFF  = 33;
`endif
    localparam int CS_LOW_A    = (1 + 2 * NB) * 2;
    localparam int DONE_LAT_A  = CS_LOW_A + 4;
    localparam int CS_LOW_B    = 1 + 2 * NB;
    localparam int DONE_LAT_B  = CS_LOW_B + 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] tx_data [2];
    logic [1:0]  tx_valid = 2'b00;
    logic [1:0]  tx_ready, sclk, cs, mosi, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_transmitter #(.CLK_DIV(2), .GAP_CYCLES(4)) u_a (
        .clk(clk), .reset(reset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .serial_clk(sclk[0]), .chip_select(cs[0]),
        .mosi(mosi[0]), .busy(busy[0]), .frame_done(done[0])
    );

    spi_transmitter #(.CLK_DIV(1), .GAP_CYCLES(4)) u_b (
        .clk(clk), .reset(reset), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .serial_clk(sclk[1]), .chip_select(cs[1]),
        .mosi(mosi[1]), .busy(busy[1]), .frame_done(done[1])
    );

    // Receiver / frame monitor, sampled on the falling clk edge.
    int          cyc = 0;
    int          rise_cnt[2] = '{0, 0};
    int          cs_low[2] = '{0, 0};
    int          ones[2] = '{0, 0};
    int          cs_high[2] = '{0, 0};
    int          busy_high[2] = '{0, 0};
    int          pmin[2] = '{1000, 1000};
    int          pmax[2] = '{0, 0};
    int          last_rise_cyc[2] = '{0, 0};
    int          fr_rise[2] = '{0, 0};
    int          fr_low[2] = '{0, 0};
    int          fr_ones[2] = '{0, 0};
    int          fr_pmin[2] = '{0, 0};
    int          fr_pmax[2] = '{0, 0};
    int          gap_high[2] = '{0, 0};
    int          gap_busy[2] = '{0, 0};
    int          frames[2] = '{0, 0};
    int          done_cnt[2] = '{0, 0};
    int          hi_glitch[2] = '{0, 0};
    logic [31:0] rx_sh[2] = '{32'h0, 32'h0};
    logic [31:0] fr_rx[2] = '{32'h0, 32'h0};
    logic [1:0]  sclk_prev = 2'b00;
    logic [1:0]  cs_prev = 2'b11;
    logic [1:0]  mosi_prev = 2'b00;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (cs[d] === 1'b0) begin
                if (cs_prev[d]) begin
                    rise_cnt[d] <= 0;
                    rx_sh[d]    <= '0;
                    cs_low[d]   <= 1;
                    ones[d]     <= mosi[d] ? 1 : 0;
                    pmin[d]     <= 1000;
                    pmax[d]     <= 0;
                    gap_high[d] <= cs_high[d];
                    gap_busy[d] <= busy_high[d];
                end else begin
                    cs_low[d] <= cs_low[d] + 1;
                    ones[d]   <= ones[d] + (mosi[d] ? 1 : 0);
                end
                if (sclk[d] && !sclk_prev[d]) begin
                    rise_cnt[d]      <= rise_cnt[d] + 1;
                    rx_sh[d]         <= {rx_sh[d][30:0], mosi[d]};
                    last_rise_cyc[d] <= cyc;
                    if (rise_cnt[d] >= 1) begin
                        if (cyc - last_rise_cyc[d] < pmin[d]) pmin[d] <= cyc - last_rise_cyc[d];
                        if (cyc - last_rise_cyc[d] > pmax[d]) pmax[d] <= cyc - last_rise_cyc[d];
                    end
                end
                if (sclk[d] && sclk_prev[d] && (mosi[d] != mosi_prev[d])) hi_glitch[d] <= hi_glitch[d] + 1;
            end else if (cs[d] === 1'b1) begin
                if (!cs_prev[d]) begin
                    fr_rise[d]   <= rise_cnt[d];
                    fr_rx[d]     <= rx_sh[d];
                    fr_low[d]    <= cs_low[d];
                    fr_ones[d]   <= ones[d];
                    fr_pmin[d]   <= pmin[d];
                    fr_pmax[d]   <= pmax[d];
                    frames[d]    <= frames[d] + 1;
                    cs_high[d]   <= 1;
                    busy_high[d] <= busy[d] ? 1 : 0;
                end else begin
                    cs_high[d]   <= cs_high[d] + 1;
                    busy_high[d] <= busy_high[d] + (busy[d] ? 1 : 0);
                end
            end
            if (done[d] === 1'b1) done_cnt[d] <= done_cnt[d] + 1;
        end
        sclk_prev <= sclk;
        cs_prev   <= cs;
        mosi_prev <= mosi;
    end

    function automatic logic [31:0] exp_rx(input logic [15:0] w);
        return (NB == 32) ? {w, 16'h0000} : {16'h0000, w};
    endfunction

    // Call while the instance is idle; returns just after the accepting edge.
    task automatic send(input int d, input logic [15:0] w);
        tx_data[d]  = w;
        tx_valid[d] = 1'b1;
        @(posedge clk);
        #1 tx_valid[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done[d] !== 1'b1 && lat < 1000);
        if (done[d] !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL frame_done_timeout[%0d]: got no pulse in %0d cycles, required one", d, lat);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tx_valid = 2'b00;
        tx_data[0] = 16'h0; tx_data[1] = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (cs[0] !== 1'b1)       begin n_fail++; $display("FAIL reset_cs: got %b required 1", cs[0]); end
        n_checks++; if (sclk[0] !== 1'b0)     begin n_fail++; $display("FAIL reset_sclk: got %b required 0", sclk[0]); end
        n_checks++; if (mosi[0] !== 1'b0)     begin n_fail++; $display("FAIL reset_mosi: got %b required 0", mosi[0]); end
        n_checks++; if (busy[0] !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy[0]); end
        n_checks++; if (done[0] !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b required 0", done[0]); end
        n_checks++; if (tx_ready[0] !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", tx_ready[0]); end
        reset = 1'b0;
        @(negedge clk);
        $display("reset: outputs idle after reset");
    endtask

    task automatic test_basic;
        int lat, d0;
        d0 = done_cnt[0];
        send(0, BASIC_WORD);
        wait_done(0, lat);
        n_checks++; if (lat !== DONE_LAT_A) begin n_fail++; $display("FAIL basic_done_latency: got %0d required %0d", lat, DONE_LAT_A); end
        n_checks++; if ({cs[0], sclk[0], mosi[0], busy[0]} !== 4'b1001) begin n_fail++; $display("FAIL basic_gap_outputs: got cs,sclk,mosi,busy=%b required 1001", {cs[0], sclk[0], mosi[0], busy[0]}); end
        @(negedge clk);
        n_checks++; if ({tx_ready[0], busy[0], done[0]} !== 3'b100) begin n_fail++; $display("FAIL basic_idle: got ready,busy,done=%b required 100", {tx_ready[0], busy[0], done[0]}); end
        repeat (2) @(negedge clk);
        n_checks++; if (fr_rise[0] !== NB) begin n_fail++; $display("FAIL basic_rise_count: got %0d required %0d", fr_rise[0], NB); end
        n_checks++; if (fr_rx[0] !== exp_rx(BASIC_WORD)) begin n_fail++; $display("FAIL basic_rx: got %h required %h", fr_rx[0], exp_rx(BASIC_WORD)); end
        n_checks++; if (fr_low[0] !== CS_LOW_A) begin n_fail++; $display("FAIL basic_cs_low: got %0d required %0d", fr_low[0], CS_LOW_A); end
        n_checks++; if (done_cnt[0] - d0 !== 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d required 1", done_cnt[0] - d0); end
        n_checks++; if (hi_glitch[0] !== 0) begin n_fail++; $display("FAIL basic_mosi_stable: got %0d changes while sclk high required 0", hi_glitch[0]); end
        $display("tx %h: latency %0d, cs low %0d, rx %h", BASIC_WORD, lat, fr_low[0], fr_rx[0]);
    endtask

    task automatic test_back_to_back;
        int lat, d0;
        d0 = done_cnt[0];
        tx_data[0]  = 16'h0001;
        tx_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        wait_done(0, lat);
        tx_data[0] = 16'h8000;
        n_checks++; if (fr_rx[0] !== exp_rx(16'h0001)) begin n_fail++; $display("FAIL b2b_rx1: got %h required %h", fr_rx[0], exp_rx(16'h0001)); end
        $display("tx 0001: rx %h", fr_rx[0]);
        @(negedge clk);
        n_checks++; if (tx_ready[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_done: got %b required 1", tx_ready[0]); end
        @(posedge clk);
        #1 tx_valid[0] = 1'b0;
        wait_done(0, lat);
        n_checks++; if (lat !== DONE_LAT_A) begin n_fail++; $display("FAIL b2b_done_latency: got %0d required %0d", lat, DONE_LAT_A); end
        repeat (2) @(negedge clk);
        n_checks++; if (fr_rx[0] !== exp_rx(16'h8000)) begin n_fail++; $display("FAIL b2b_rx2: got %h required %h", fr_rx[0], exp_rx(16'h8000)); end
        n_checks++; if (gap_busy[0] !== 4) begin n_fail++; $display("FAIL b2b_gap_cycles: got %0d required 4", gap_busy[0]); end
        // The gap is GAP_CYCLES long; the single IDLE cycle that accepts the next word also keeps chip_select high.
        n_checks++; if (gap_high[0] !== 5) begin n_fail++; $display("FAIL b2b_cs_high: got %0d required 5", gap_high[0]); end
        n_checks++; if (done_cnt[0] - d0 !== 2) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d required 2", done_cnt[0] - d0); end
        $display("tx 8000: rx %h, gap %0d, cs high %0d", fr_rx[0], gap_busy[0], gap_high[0]);
    endtask

    task automatic test_ignore_busy;
        int lat, d0, f0, rdy;
        d0 = done_cnt[0];
        f0 = frames[0];
        send(0, 16'h1C2D);
        repeat (20) @(negedge clk);
        tx_data[0]  = 16'hFFFF;
        tx_valid[0] = 1'b1;
        rdy = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx_ready[0] !== 1'b0) rdy++;
        end
        tx_valid[0] = 1'b0;
        n_checks++; if (rdy !== 0) begin n_fail++; $display("FAIL ignore_ready_busy: got %0d ready cycles required 0", rdy); end
        wait_done(0, lat);
        n_checks++; if (tx_ready[0] !== 1'b0) begin n_fail++; $display("FAIL ignore_ready_at_done: got %b required 0", tx_ready[0]); end
        @(negedge clk);
        n_checks++; if (tx_ready[0] !== 1'b1) begin n_fail++; $display("FAIL ignore_ready_after_done: got %b required 1", tx_ready[0]); end
        repeat (10) @(negedge clk);
        n_checks++; if (fr_rx[0] !== exp_rx(16'h1C2D)) begin n_fail++; $display("FAIL ignore_rx: got %h required %h", fr_rx[0], exp_rx(16'h1C2D)); end
        n_checks++; if (frames[0] - f0 !== 1) begin n_fail++; $display("FAIL ignore_frames: got %0d required 1", frames[0] - f0); end
        n_checks++; if (done_cnt[0] - d0 !== 1) begin n_fail++; $display("FAIL ignore_done_pulses: got %0d required 1", done_cnt[0] - d0); end
        $display("tx 1C2D with FFFF pulsed mid-frame: rx %h", fr_rx[0]);
    endtask

    task automatic test_reset_mid;
        int lat, d0, r, n;
        logic p;
        send(0, 16'hBEEF);
        r = 0; n = 0; p = 1'b0;
        while (r < 7 && n < 2000) begin
            @(negedge clk);
            n++;
            if (sclk[0] && !p) r++;
            p = sclk[0];
        end
        n_checks++; if (r !== 7) begin n_fail++; $display("FAIL rstmid_rise_wait: got %0d edges required 7", r); end
        d0 = done_cnt[0];
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if ({cs[0], sclk[0], mosi[0], busy[0], done[0], tx_ready[0]} !== 6'b100001) begin
            n_fail++; $display("FAIL rstmid_outputs: got cs,sclk,mosi,busy,done,ready=%b required 100001", {cs[0], sclk[0], mosi[0], busy[0], done[0], tx_ready[0]});
        end
        reset = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++; if (done_cnt[0] !== d0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses required 0", done_cnt[0] - d0); end
        send(0, 16'h1234);
        wait_done(0, lat);
        n_checks++; if (lat !== DONE_LAT_A) begin n_fail++; $display("FAIL rstmid_done_latency: got %0d required %0d", lat, DONE_LAT_A); end
        repeat (2) @(negedge clk);
        n_checks++; if (fr_rx[0] !== exp_rx(16'h1234)) begin n_fail++; $display("FAIL rstmid_rx: got %h required %h", fr_rx[0], exp_rx(16'h1234)); end
        $display("tx BEEF aborted after 7 edges, tx 1234: rx %h", fr_rx[0]);
    endtask

    task automatic test_div1;
        int lat;
        send(1, 16'hFFFF);
        wait_done(1, lat);
        n_checks++; if (lat !== DONE_LAT_B) begin n_fail++; $display("FAIL div1_done_latency: got %0d required %0d", lat, DONE_LAT_B); end
        repeat (2) @(negedge clk);
        n_checks++; if (fr_low[1] !== CS_LOW_B) begin n_fail++; $display("FAIL div1_cs_low_ffff: got %0d required %0d", fr_low[1], CS_LOW_B); end
        n_checks++; if (fr_ones[1] !== ONES_FFFF) begin n_fail++; $display("FAIL div1_mosi_ffff: got %0d high cycles required %0d", fr_ones[1], ONES_FFFF); end
        n_checks++; if (fr_rise[1] !== NB) begin n_fail++; $display("FAIL div1_rise_count: got %0d required %0d", fr_rise[1], NB); end
        n_checks++; if (fr_pmin[1] !== 2 || fr_pmax[1] !== 2) begin n_fail++; $display("FAIL div1_period: got %0d..%0d required 2..2", fr_pmin[1], fr_pmax[1]); end
        n_checks++; if (fr_rx[1] !== exp_rx(16'hFFFF)) begin n_fail++; $display("FAIL div1_rx_ffff: got %h required %h", fr_rx[1], exp_rx(16'hFFFF)); end
        $display("div1 tx FFFF: cs low %0d, mosi high %0d, rx %h", fr_low[1], fr_ones[1], fr_rx[1]);
        send(1, 16'h0000);
        wait_done(1, lat);
        repeat (2) @(negedge clk);
        n_checks++; if (fr_low[1] !== CS_LOW_B) begin n_fail++; $display("FAIL div1_cs_low_0000: got %0d required %0d", fr_low[1], CS_LOW_B); end
        n_checks++; if (fr_ones[1] !== 0) begin n_fail++; $display("FAIL div1_mosi_0000: got %0d high cycles required 0", fr_ones[1]); end
        n_checks++; if (hi_glitch[1] !== 0) begin n_fail++; $display("FAIL div1_mosi_stable: got %0d changes while sclk high required 0", hi_glitch[1]); end
        $display("div1 tx 0000: cs low %0d, mosi high %0d, rx %h", fr_low[1], fr_ones[1], fr_rx[1]);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_div1();
        n_checks++; if (hi_glitch[0] !== 0) begin n_fail++; $display("FAIL final_mosi_stable: got %0d changes while sclk high required 0", hi_glitch[0]); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got simulation still running required completion");
        $fatal(1, "timeout");
    end

endmodule
